// File: rtl/reg_file_bist_if.sv
// Register-file access port shared by the BIST initiator and the register file.
interface reg_file_bist_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 4
);
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/reg_file_bist.sv
// Register-file BIST initiator: two-pass write / read-back sweep (address pattern,
// then its inverse), reporting pass/fail, a saturating error count and the first
// failing address. All outputs are registered.
module reg_file_bist #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 4,
  parameter int unsigned CW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CW-1:0]     err_count,
  output logic [AW-1:0]     fail_addr,
  reg_file_bist_if.master   rf
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StDone} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e        state_q;
  logic          phase_q;      // 0: address pattern, 1: inverted pattern
  logic          seen_q;       // first mismatch already latched
  logic          busy_q, done_q, pass_q, we_q;
  logic [CW-1:0] err_q;
  logic [AW-1:0] fail_q, addr_q;
  logic [DW-1:0] wdata_q;

  logic [DW-1:0] exp_data;
  logic          mismatch;
  logic [CW-1:0] err_next;

  // Address zero-extended or truncated to DW, optionally inverted.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic inv);
    logic [AW+DW-1:0] ext;
    ext = {{DW{1'b0}}, a};
    return inv ? ~ext[DW-1:0] : ext[DW-1:0];
  endfunction

  // Read-back compare and saturating error-count update for the current RD cycle.
  always_comb begin
    exp_data = pattern(addr_q, phase_q);
    mismatch = (state_q == StRd) && (rf.rdata != exp_data);
    err_next = err_q;
    if (mismatch && (err_q != {CW{1'b1}})) begin
      err_next = err_q + CW'(1);
    end
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= 1'b0;
      seen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StWr;
            phase_q <= 1'b0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            we_q    <= 1'b1;
            err_q   <= '0;
            fail_q  <= '0;
            addr_q  <= '0;
            wdata_q <= pattern('0, 1'b0);
          end else begin
            state_q <= StIdle;
          end
        end
        StWr: begin
          if (addr_q == LastAddr) begin
            state_q <= StRd;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
          end else begin
            addr_q  <= addr_q + AW'(1);
            wdata_q <= pattern(addr_q + AW'(1), phase_q);
          end
        end
        StRd: begin
          err_q <= err_next;
          if (mismatch && !seen_q) begin
            fail_q <= addr_q;
            seen_q <= 1'b1;
          end
          if (addr_q == LastAddr) begin
            addr_q <= '0;
            if (!phase_q) begin
              state_q <= StWr;
              phase_q <= 1'b1;
              we_q    <= 1'b1;
              wdata_q <= pattern('0, 1'b1);
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_next == '0);
            end
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;
  assign rf.we     = we_q;
  assign rf.addr   = addr_q;
  assign rf.wdata  = wdata_q;

endmodule

// File: tb/tb_reg_file_bist.sv
// Directed bench for reg_file_bist: behavioural 8x4 register file with an optional
// stuck-at-0 fault, plus a second instance (CW=3) whose read data is tied to zero.
module tb_reg_file_bist;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start_z;
  logic stuck_en;

  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_addr;
  logic       busy_z, done_z, pass_z;
  logic [2:0] err_count_z;
  logic [2:0] fail_addr_z;

  int n_pass  = 0;
  int n_total = 0;
  int cyc;

  logic [3:0] mem [8];

  always #5 clk = ~clk;

  reg_file_bist_if #(.AW(3), .DW(4)) rf_a ();
  reg_file_bist_if #(.AW(3), .DW(4)) rf_z ();

  reg_file_bist #(.DEPTH(8), .AW(3), .DW(4), .CW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .rf        (rf_a)
  );

  reg_file_bist #(.DEPTH(8), .AW(3), .DW(4), .CW(3)) dut_z (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_z),
    .busy      (busy_z),
    .done      (done_z),
    .pass      (pass_z),
    .err_count (err_count_z),
    .fail_addr (fail_addr_z),
    .rf        (rf_z)
  );

  // Behavioural register file; entry 5 bit 0 optionally stuck at 0 on read.
  always @(posedge clk) begin
    if (rf_a.we) mem[rf_a.addr] <= rf_a.wdata;
  end
  assign rf_a.rdata = (stuck_en && rf_a.addr == 3'd5) ? (mem[rf_a.addr] & 4'b1110)
                                                      : mem[rf_a.addr];
  assign rf_z.rdata = 4'b0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Ticks until done (bounded); optionally pulses start at a given cycle.
  task automatic wait_done(input bit z, input int pulse_at, output int c);
    c = 0;
    while (!(z ? done_z : done) && c < 64) begin
      if (c == pulse_at) start = 1'b1;
      tick();
      if (c == pulse_at) start = 1'b0;
      c++;
    end
  endtask

  function automatic logic [31:0] mem_image();
    return {mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]};
  endfunction

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    start_z  = 1'b0;
    stuck_en = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check("rst_outs", {busy, done, pass, err_count, fail_addr}, 32'h0);
    check("rst_port", {rf_a.we, rf_a.addr, rf_a.wdata}, 32'h0);
    check("rst_outs_z", {busy_z, done_z, pass_z, err_count_z, fail_addr_z}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Clean run with cycle-level probes.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("e0_port", {busy, rf_a.we, rf_a.addr, rf_a.wdata}, {1'b1, 1'b1, 3'd0, 4'h0});
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c == 1)  check("e1_port", {rf_a.we, rf_a.addr, rf_a.wdata}, {1'b1, 3'd1, 4'h1});
      if (c == 8)  check("e8_rd", {busy, rf_a.we, rf_a.addr, rf_a.wdata}, {1'b1, 1'b0, 3'd0, 4'h0});
      if (c == 16) check("e16_wr1", {rf_a.we, rf_a.addr, rf_a.wdata}, {1'b1, 3'd0, 4'hf});
      if (c == 21) check("e21_wr1", {rf_a.we, rf_a.addr, rf_a.wdata}, {1'b1, 3'd5, 4'ha});
      if (c == 31) check("e31_nodone", {busy, done}, {1'b1, 1'b0});
    end
    check("clean_done", {busy, done, rf_a.we}, {1'b0, 1'b1, 1'b0});
    check("clean_res", {pass, err_count, fail_addr}, {1'b1, 4'd0, 3'd0});
    check("clean_mem", mem_image(), 32'h89abcdef);
    tick();
    check("clean_done_pulse", {busy, done, pass}, {1'b0, 1'b0, 1'b1});

    // Stuck-at-0 on entry 5 bit 0, with an ignored start pulse at cycle 10.
    stuck_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("stuck_clear", {busy, pass, err_count}, {1'b1, 1'b0, 4'd0});
    wait_done(1'b0, 10, cyc);
    check("stuck_cycles", cyc, 32);
    check("stuck_res", {pass, err_count, fail_addr}, {1'b0, 4'd1, 3'd5});
    tick();
    check("stuck_idle", {busy, done}, {1'b0, 1'b0});

    // Read data tied to zero, CW=3: count saturates at 7, first fail at 1.
    start_z = 1'b1;
    tick();
    start_z = 1'b0;
    wait_done(1'b1, -1, cyc);
    check("zero_cycles", cyc, 32);
    check("zero_res", {pass_z, err_count_z, fail_addr_z}, {1'b0, 3'd7, 3'd1});

    // Start held high: back-to-back sweeps, re-accept in the DONE cycle.
    start = 1'b1;
    tick();
    wait_done(1'b0, -1, cyc);
    check("hold1_cycles", cyc, 32);
    check("hold1_res", {pass, err_count, fail_addr}, {1'b0, 4'd1, 3'd5});
    tick();
    check("hold_reaccept", {busy, done, rf_a.we, pass, err_count, fail_addr},
          {1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0});
    wait_done(1'b0, -1, cyc);
    start = 1'b0;
    check("hold2_cycles", cyc, 32);
    check("hold2_res", {pass, err_count, fail_addr}, {1'b0, 4'd1, 3'd5});
    tick();
    check("hold_release", {busy, done}, {1'b0, 1'b0});

    // Asynchronous reset in the middle of the write phase.
    stuck_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_wr", {rf_a.we, rf_a.addr}, {1'b1, 3'd2});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {rf_a.we, busy, rf_a.addr, rf_a.wdata}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, -1, cyc);
    check("post_rst_cycles", cyc, 32);
    check("post_rst_res", {pass, err_count, fail_addr}, {1'b1, 4'd0, 3'd0});
    check("post_rst_mem", mem_image(), 32'h89abcdef);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
